// File: rtl/imem_bram_resp_if.sv
// Fetch and program-loader signal bundle for the instruction-memory responder.
// The master side is the fetch stage plus the byte source; the slave side is the memory.
interface imem_bram_resp_if #(
    parameter int ADDR_W = 11
);
    logic              fetch_en_i;
    logic [31:0]       fetch_addr_i;
    logic [31:0]       instr_o;
    logic              instr_valid_o;
    logic              fetch_err_o;
    logic              load_start_i;
    logic [ADDR_W-1:0] load_base_i;
    logic [ADDR_W:0]   load_len_i;
    logic [7:0]        ld_data_i;
    logic              ld_valid_i;
    logic              ld_ready_o;
    logic              load_busy_o;
    logic              load_done_o;
    logic              load_err_o;

    modport master (
        output fetch_en_i, fetch_addr_i, load_start_i, load_base_i, load_len_i,
               ld_data_i, ld_valid_i,
        input  instr_o, instr_valid_o, fetch_err_o, ld_ready_o, load_busy_o,
               load_done_o, load_err_o
    );

    modport slave (
        input  fetch_en_i, fetch_addr_i, load_start_i, load_base_i, load_len_i,
               ld_data_i, ld_valid_i,
        output instr_o, instr_valid_o, fetch_err_o, ld_ready_o, load_busy_o,
               load_done_o, load_err_o
    );
endinterface

// File: rtl/imem_bram_resp.sv
// Byte-addressed instruction memory: 1-cycle 32-bit fetch reads with range flagging,
// plus a valid/ready byte-stream loader that fills the memory between runs.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for load_start_i; fetches are served
//   S_LOAD | accepting bytes at ptr, rem bytes still to come
//   S_DONE | single-cycle load_done_o pulse, then back to S_IDLE
module imem_bram_resp #(
    parameter int          ADDR_W      = 11,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    imem_bram_resp_if.slave bus
);
    localparam int unsigned           MEM_BYTES = 2 ** ADDR_W;
    localparam logic [ADDR_W+1:0]     MEM_SIZE  = (ADDR_W + 2)'(MEM_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              load_err_q, load_err_d;

    logic [7:0]        mem [MEM_BYTES];

    logic              busy;
    logic              accept;
    logic [ADDR_W+1:0] load_end;
    logic              load_range_err;

    logic [ADDR_W-1:0] idx0, idx1, idx2, idx3;
    logic [ADDR_W:0]   fetch_end;
    logic              fetch_err;
    logic [31:0]       rd_word;

    logic [31:0]       instr_q;
    logic              instr_valid_q;
    logic              fetch_err_q;

    assign busy   = (state_q != S_IDLE);
    assign accept = (state_q == S_LOAD) && bus.ld_valid_i;

    // Widened by two bits so base + len can never wrap before the compare.
    assign load_end       = {2'b00, bus.load_base_i} + {1'b0, bus.load_len_i};
    assign load_range_err = (load_end > MEM_SIZE);

    // ---------------- loader FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            load_err_q <= load_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        load_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.load_start_i) begin
                    if (load_range_err) begin
                        load_err_d = 1'b1;
                    end else if (bus.load_len_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = bus.load_base_i;
                        rem_d   = bus.load_len_i;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == (ADDR_W + 1)'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory has no reset so loaded code survives a reset pulse.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[ptr_q] <= bus.ld_data_i;
        end
    end

    // ---------------- fetch path ----------------
    assign idx0      = bus.fetch_addr_i[ADDR_W-1:0];
    assign idx1      = idx0 + (ADDR_W)'(1);
    assign idx2      = idx0 + (ADDR_W)'(2);
    assign idx3      = idx0 + (ADDR_W)'(3);
    assign fetch_end = {1'b0, idx0} + (ADDR_W + 1)'(3);
    assign fetch_err = (|bus.fetch_addr_i[31:ADDR_W]) | fetch_end[ADDR_W];
    assign rd_word   = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q       <= RESET_INSTR;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else if (!bus.fetch_en_i) begin
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else if (busy) begin
            instr_q       <= RESET_INSTR;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            instr_q       <= fetch_err ? RESET_INSTR : rd_word;
            instr_valid_q <= ~fetch_err;
            fetch_err_q   <= fetch_err;
        end
    end

    assign bus.instr_o       = instr_q;
    assign bus.instr_valid_o = instr_valid_q;
    assign bus.fetch_err_o   = fetch_err_q;
    assign bus.ld_ready_o    = (state_q == S_LOAD);
    assign bus.load_busy_o   = busy;
    assign bus.load_done_o   = (state_q == S_DONE);
    assign bus.load_err_o    = load_err_q;
endmodule

// File: tb/tb_imem_bram_resp.sv
// Directed bench for imem_bram_resp: fetch expectations go through a scoreboard queue
// consumed by a negedge monitor; loader handshakes are checked inline.
module tb_imem_bram_resp;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    imem_bram_resp_if #(.ADDR_W(11)) bus ();

    imem_bram_resp #(.ADDR_W(11), .RESET_INSTR(32'h0000_0013)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc = cyc + 1;

    typedef struct {
        logic [31:0] instr;
        logic        v;
        logic        e;
        int          at;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: consumes one expectation on the cycle it is due
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (sbq.size() > 0 && sbq[0].at == cyc) begin
                exp_t e;
                e = sbq.pop_front();
                chk("mon_instr", bus.instr_o, e.instr);
                chk("mon_valid", {31'b0, bus.instr_valid_o}, {31'b0, e.v});
                chk("mon_err",   {31'b0, bus.fetch_err_o},   {31'b0, e.e});
            end else if (bus.instr_valid_o || bus.fetch_err_o) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL mon_unexpected: valid=%b err=%b with no pending fetch (cycle %0d)",
                         bus.instr_valid_o, bus.fetch_err_o, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] ei, input logic ev, input logic ee);
        exp_t e;
        bus.fetch_en_i   = 1'b1;
        bus.fetch_addr_i = addr;
        e.instr = ei; e.v = ev; e.e = ee; e.at = cyc + 1;
        sbq.push_back(e);
        tick();
        bus.fetch_en_i = 1'b0;
    endtask

    task automatic hold_check(input logic [31:0] ei);
        exp_t e;
        bus.fetch_en_i = 1'b0;
        e.instr = ei; e.v = 1'b0; e.e = 1'b0; e.at = cyc + 1;
        sbq.push_back(e);
        tick();
    endtask

    // abort_at != 0: assert reset right after that many accepted bytes
    task automatic do_load(input logic [10:0] base, input logic [11:0] len, input logic [63:0] data,
                           input bit gap, input int abort_at);
        int  acc = 0;
        int  k = 0;
        bit  early_done = 0;
        bit  take;
        bus.load_base_i  = base;
        bus.load_len_i   = len;
        bus.load_start_i = 1'b1;
        tick();
        bus.load_start_i = 1'b0;
        chk("busy_after_start", {31'b0, bus.load_busy_o}, 32'd1);
        while (acc < int'(len) && k < 200) begin
            bus.ld_valid_i = gap ? (k % 3 == 0) : 1'b1;
            bus.ld_data_i  = bus.ld_valid_i ? data[8*acc +: 8] : 8'h5a;
            take = bus.ld_valid_i && bus.ld_ready_o;
            tick();
            if (take) acc = acc + 1;
            if (bus.load_done_o && acc < int'(len)) early_done = 1;
            k = k + 1;
            if (abort_at != 0 && acc == abort_at) begin
                bus.ld_valid_i = 1'b0;
                rst_ni = 1'b0;
                #1;
                chk("rst_busy",  {31'b0, bus.load_busy_o}, 32'd0);
                chk("rst_ready", {31'b0, bus.ld_ready_o},  32'd0);
                chk("rst_instr", bus.instr_o, 32'h0000_0013);
                return;
            end
        end
        bus.ld_valid_i = 1'b0;
        chk("load_accepts", acc, int'(len));
        chk("no_early_done", {31'b0, early_done}, 32'd0);
        chk("done_pulse",   {31'b0, bus.load_done_o}, 32'd1);
        chk("ready_dropped", {31'b0, bus.ld_ready_o}, 32'd0);
        tick();
        chk("done_cleared", {31'b0, bus.load_done_o}, 32'd0);
        chk("idle_after",   {31'b0, bus.load_busy_o}, 32'd0);
    endtask

    initial begin
        bus.fetch_en_i   = 1'b0;
        bus.fetch_addr_i = '0;
        bus.load_start_i = 1'b0;
        bus.load_base_i  = '0;
        bus.load_len_i   = '0;
        bus.ld_data_i    = '0;
        bus.ld_valid_i   = 1'b0;

        #12;
        chk("reset_instr", bus.instr_o, 32'h0000_0013);
        chk("reset_valid", {31'b0, bus.instr_valid_o}, 32'd0);
        chk("reset_ferr",  {31'b0, bus.fetch_err_o},   32'd0);
        chk("reset_ready", {31'b0, bus.ld_ready_o},    32'd0);
        chk("reset_busy",  {31'b0, bus.load_busy_o},   32'd0);
        chk("reset_done",  {31'b0, bus.load_done_o},   32'd0);
        chk("reset_lerr",  {31'b0, bus.load_err_o},    32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // basic load and fetches, including a misaligned one
        do_load(11'h000, 12'd8, 64'h0050_0593_00a0_0513, 1'b0, 0);
        fetch(32'h0, 32'h00a0_0513, 1'b1, 1'b0);
        fetch(32'h4, 32'h0050_0593, 1'b1, 1'b0);
        fetch(32'h2, 32'h0593_00a0, 1'b1, 1'b0);
        do_load(11'h008, 12'd4, 64'h0000_0000_efbe_adde, 1'b0, 0);
        fetch(32'h8, 32'hefbe_adde, 1'b1, 1'b0);

        // gapped valid: only accepted beats count, byte 8 onward untouched
        do_load(11'h000, 12'd8, 64'h0807_0605_0403_0201, 1'b1, 0);
        fetch(32'h0, 32'h0403_0201, 1'b1, 1'b0);
        fetch(32'h4, 32'h0807_0605, 1'b1, 1'b0);
        fetch(32'h6, 32'hadde_0807, 1'b1, 1'b0);

        // top-of-memory boundary
        do_load(11'h7fc, 12'd4, 64'h0000_0000_4433_2211, 1'b0, 0);
        fetch(32'h7fc, 32'h4433_2211, 1'b1, 1'b0);
        fetch(32'h7fd, 32'h0000_0013, 1'b0, 1'b1);
        fetch(32'h7fe, 32'h0000_0013, 1'b0, 1'b1);
        fetch(32'h800, 32'h0000_0013, 1'b0, 1'b1);
        fetch(32'h0001_0000, 32'h0000_0013, 1'b0, 1'b1);

        // out-of-range load request
        bus.load_base_i  = 11'h7fc;
        bus.load_len_i   = 12'd8;
        bus.load_start_i = 1'b1;
        tick();
        bus.load_start_i = 1'b0;
        chk("lerr_pulse", {31'b0, bus.load_err_o},  32'd1);
        chk("lerr_busy",  {31'b0, bus.load_busy_o}, 32'd0);
        tick();
        chk("lerr_cleared", {31'b0, bus.load_err_o}, 32'd0);
        fetch(32'h7fc, 32'h4433_2211, 1'b1, 1'b0);

        // fetch masked while loading, then hold with fetch_en low
        bus.load_base_i  = 11'h010;
        bus.load_len_i   = 12'd1;
        bus.load_start_i = 1'b1;
        tick();
        bus.load_start_i = 1'b0;
        chk("ld_ready_first", {31'b0, bus.ld_ready_o}, 32'd1);
        fetch(32'h0, 32'h0000_0013, 1'b0, 1'b0);
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = 8'h77;
        tick();
        bus.ld_valid_i = 1'b0;
        chk("single_done", {31'b0, bus.load_done_o}, 32'd1);
        tick();
        fetch(32'h0, 32'h0403_0201, 1'b1, 1'b0);
        hold_check(32'h0403_0201);
        hold_check(32'h0403_0201);

        // reset after 3 of 8 bytes; partial bytes persist
        do_load(11'h000, 12'd8, 64'h0201_ffee_ddcc_bbaa, 1'b0, 3);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        fetch(32'h0, 32'h04cc_bbaa, 1'b1, 1'b0);

        // zero-length load: done pulse, nothing written
        do_load(11'h000, 12'd0, 64'h0, 1'b0, 0);
        fetch(32'h0, 32'h04cc_bbaa, 1'b1, 1'b0);

        tick();
        tick();
        if (sbq.size() != 0) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL sb_drain: %0d expectations never consumed, expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench still running at %0t, expected to finish", $time);
        $fatal(1, "timeout");
    end
endmodule
